// File: rtl/div_ctrl.sv
// div_ctrl: EX-stage sequencer for the shared radix-4 unsigned divider.
// Converts DIV/DIVU operands to magnitudes, launches the divider, stalls
// the pipeline while it runs, applies the sign fix-up and strobes HI/LO.
// A one-entry result cache serves repeated operand pairs, because the
// divider will not restart on a pair it has just computed.
module div_ctrl #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         issue_valid,
    input  logic         issue_signed,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         flush,
    output logic         stall_o,
    output logic         hilo_we,
    output logic [W-1:0] hi_o,
    output logic [W-1:0] lo_o,
    output logic         div0_o,
    output logic         div_en,
    output logic [W-1:0] div_divident,
    output logic [W-1:0] div_divisor,
    input  logic [W-1:0] div_quotient,
    input  logic [W-1:0] div_remainder,
    input  logic         div_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_BUSY,
        S_FIXUP,
        S_DRAIN
    } state_t;

    state_t       r_state;

    // Pair presented to the divider; only changes when a launch is decided
    logic [W-1:0] r_div_a;
    logic [W-1:0] r_div_b;

    // One-entry cache: always mirrors the last pair the divider accepted
    logic         r_cache_vld;
    logic [W-1:0] r_cache_a;
    logic [W-1:0] r_cache_b;
    logic [W-1:0] r_cache_q;
    logic [W-1:0] r_cache_r;

    // Unsigned result and sign info consumed in FIXUP
    logic [W-1:0] r_q;
    logic [W-1:0] r_r;
    logic         r_sign_q;
    logic         r_sign_r;
    logic         r_div0;
    logic         r_seen_low;

    // Last written HI/LO values, held while no write strobe is present
    logic [W-1:0] r_hi;
    logic [W-1:0] r_lo;

    logic         w_a_neg;
    logic         w_b_neg;
    logic [W-1:0] w_mag_a;
    logic [W-1:0] w_mag_b;
    logic         w_accept;
    logic         w_hit;
    logic         w_div_fin;
    logic         w_hilo_we;
    logic [W-1:0] w_lo_fix;
    logic [W-1:0] w_hi_fix;

    // Operand magnitudes, cache lookup and divider completion detect
    always_comb begin
        w_a_neg   = issue_signed & op_a[W-1];
        w_b_neg   = issue_signed & op_b[W-1];
        w_mag_a   = w_a_neg ? -op_a : op_a;
        w_mag_b   = w_b_neg ? -op_b : op_b;
        w_accept  = (r_state == S_IDLE) & issue_valid & ~flush;
        w_hit     = r_cache_vld & (w_mag_a == r_cache_a) & (w_mag_b == r_cache_b);
        w_div_fin = div_done & r_seen_low;
    end

    // Sign fix-up and output drive; the write strobe is gated by flush in
    // the same cycle, so HI/LO are muxed rather than registered on FIXUP entry
    always_comb begin
        w_lo_fix     = r_sign_q ? -r_q : r_q;
        w_hi_fix     = r_sign_r ? -r_r : r_r;
        w_hilo_we    = (r_state == S_FIXUP) & ~r_div0 & ~flush;
        hilo_we      = w_hilo_we;
        div0_o       = (r_state == S_FIXUP) & r_div0 & ~flush;
        lo_o         = w_hilo_we ? w_lo_fix : r_lo;
        hi_o         = w_hilo_we ? w_hi_fix : r_hi;
        div_en       = (r_state == S_LAUNCH);
        stall_o      = (r_state == S_LAUNCH) | (r_state == S_BUSY) |
                       ((r_state == S_IDLE) & issue_valid & ~flush);
        div_divident = r_div_a;
        div_divisor  = r_div_b;
    end

    // Sequencer state, cache maintenance and HI/LO hold registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_div_a     <= '0;
            r_div_b     <= '0;
            r_cache_vld <= 1'b0;
            r_cache_a   <= '0;
            r_cache_b   <= '0;
            r_cache_q   <= '0;
            r_cache_r   <= '0;
            r_q         <= '0;
            r_r         <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_div0      <= 1'b0;
            r_seen_low  <= 1'b0;
            r_hi        <= '0;
            r_lo        <= '0;
        end else begin
            if (w_hilo_we) begin
                r_hi <= w_hi_fix;
                r_lo <= w_lo_fix;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_sign_q <= w_a_neg ^ w_b_neg;
                        r_sign_r <= w_a_neg;
                        if (op_b == '0) begin
                            r_div0  <= 1'b1;
                            r_state <= S_FIXUP;
                        end else if (w_hit) begin
                            r_div0  <= 1'b0;
                            r_q     <= r_cache_q;
                            r_r     <= r_cache_r;
                            r_state <= S_FIXUP;
                        end else begin
                            r_div0     <= 1'b0;
                            r_div_a    <= w_mag_a;
                            r_div_b    <= w_mag_b;
                            r_seen_low <= 1'b0;
                            r_state    <= S_LAUNCH;
                        end
                    end
                end
                S_LAUNCH: begin
                    if (!div_done)
                        r_seen_low <= 1'b1;
                    r_state <= flush ? S_DRAIN : S_BUSY;
                end
                S_BUSY: begin
                    if (flush) begin
                        if (!div_done)
                            r_seen_low <= 1'b1;
                        r_state <= S_DRAIN;
                    end else if (w_div_fin) begin
                        r_cache_vld <= 1'b1;
                        r_cache_a   <= r_div_a;
                        r_cache_b   <= r_div_b;
                        r_cache_q   <= div_quotient;
                        r_cache_r   <= div_remainder;
                        r_q         <= div_quotient;
                        r_r         <= div_remainder;
                        r_seen_low  <= 1'b0;
                        r_state     <= S_FIXUP;
                    end else if (!div_done) begin
                        r_seen_low <= 1'b1;
                    end
                end
                S_DRAIN: begin
                    if (w_div_fin) begin
                        r_cache_vld <= 1'b1;
                        r_cache_a   <= r_div_a;
                        r_cache_b   <= r_div_b;
                        r_cache_q   <= div_quotient;
                        r_cache_r   <= div_remainder;
                        r_seen_low  <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (!div_done) begin
                        r_seen_low <= 1'b1;
                    end
                end
                S_FIXUP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed test of the divider sequencer against a
// behavioural 17-busy-cycle divider that refuses to restart on a repeated pair.
module tb_div_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic        issue_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        flush;
    logic        stall_o;
    logic        hilo_we;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        div0_o;
    logic        div_en;
    logic [31:0] div_divident;
    logic [31:0] div_divisor;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;
    logic        div_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    div_ctrl #(.W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .issue_valid  (issue_valid),
        .issue_signed (issue_signed),
        .op_a         (op_a),
        .op_b         (op_b),
        .flush        (flush),
        .stall_o      (stall_o),
        .hilo_we      (hilo_we),
        .hi_o         (hi_o),
        .lo_o         (lo_o),
        .div0_o       (div0_o),
        .div_en       (div_en),
        .div_divident (div_divident),
        .div_divisor  (div_divisor),
        .div_quotient (div_quotient),
        .div_remainder(div_remainder),
        .div_done     (div_done)
    );

    // Behavioural divider: busy 17 cycles after an accepted start, results
    // only become visible when done returns high.
    logic [31:0] m_last_a, m_last_b, m_q, m_r;
    logic        m_last_vld;
    int          m_cnt;

    always @(posedge clk) begin
        if (!rst) begin
            div_done      <= 1'b1;
            div_quotient  <= 32'h0;
            div_remainder <= 32'h0;
            m_last_vld    <= 1'b0;
            m_last_a      <= 32'h0;
            m_last_b      <= 32'h0;
            m_cnt         <= 0;
        end else if (div_en && div_done && div_divisor != 0 &&
                     !(m_last_vld && div_divident == m_last_a && div_divisor == m_last_b)) begin
            div_done      <= 1'b0;
            div_quotient  <= 32'hDEAD_BEEF;
            div_remainder <= 32'hDEAD_BEEF;
            m_cnt         <= 17;
            m_last_vld    <= 1'b1;
            m_last_a      <= div_divident;
            m_last_b      <= div_divisor;
            m_q           <= div_divident / div_divisor;
            m_r           <= div_divident % div_divisor;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 1) begin
                div_done      <= 1'b1;
                div_quotient  <= m_q;
                div_remainder <= m_r;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one op at the start of a cycle and follow it to its result cycle.
    // exp_lat < 0 means only the result values are checked.
    task automatic do_op(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input int exp_stall,
                         input int exp_en, input logic exp_d0,
                         input logic [31:0] elo, input logic [31:0] ehi);
        int          cyc, res, st, en;
        logic        st_res, we_f, d0_f;
        logic [31:0] lo_s, hi_s;
        issue_valid  = 1'b1;
        issue_signed = sg;
        op_a         = a;
        op_b         = b;
        cyc = 0; res = -1; st = 0; en = 0;
        st_res = 1'b1; we_f = 1'b0; d0_f = 1'b0; lo_s = 32'h0; hi_s = 32'h0;
        while (res < 0 && cyc < 200) begin
            @(negedge clk);
            if (div_en) en++;
            if (hilo_we || div0_o) begin
                res = cyc; st_res = stall_o; we_f = hilo_we; d0_f = div0_o;
                lo_s = lo_o; hi_s = hi_o;
            end else if (stall_o) begin
                st++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        issue_valid = 1'b0;
        if (exp_lat >= 0) begin
            check({tag, " latency"}, 32'(res), 32'(exp_lat));
            check({tag, " stall cycles"}, 32'(st), 32'(exp_stall));
            check({tag, " div_en cycles"}, 32'(en), 32'(exp_en));
        end else begin
            check({tag, " completed"}, 32'(res >= 0), 32'd1);
        end
        check({tag, " stall at result"}, 32'(st_res), 32'd0);
        check({tag, " hilo_we"}, 32'(we_f), 32'(!exp_d0));
        check({tag, " div0_o"}, 32'(d0_f), 32'(exp_d0));
        check({tag, " lo"}, lo_s, elo);
        check({tag, " hi"}, hi_s, ehi);
    endtask

    // DIVU squashed by a flush at cycle 5 of its run; returns at cycle 8
    task automatic flush_op(input string tag, input logic [31:0] a, input logic [31:0] b);
        int   we, en;
        logic st5, st6, st7;
        we = 0; en = 0; st5 = 1'b0; st6 = 1'b1; st7 = 1'b1;
        issue_valid  = 1'b1;
        issue_signed = 1'b0;
        op_a         = a;
        op_b         = b;
        for (int c = 0; c < 8; c++) begin
            if (c == 5) flush = 1'b1;
            if (c == 6) begin flush = 1'b0; issue_valid = 1'b0; end
            @(negedge clk);
            if (hilo_we) we++;
            if (div_en) en++;
            if (c == 5) st5 = stall_o;
            if (c == 6) st6 = stall_o;
            if (c == 7) st7 = stall_o;
            @(posedge clk); #1;
        end
        check({tag, " stall c5"}, 32'(st5), 32'd1);
        check({tag, " stall c6"}, 32'(st6), 32'd0);
        check({tag, " stall c7"}, 32'(st7), 32'd0);
        check({tag, " hilo_we count"}, 32'(we), 32'd0);
        check({tag, " div_en count"}, 32'(en), 32'd1);
    endtask

    initial begin
        rst = 1'b0; issue_valid = 1'b0; issue_signed = 1'b0;
        op_a = 32'h0; op_b = 32'h0; flush = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset ctrl", {28'h0, stall_o, hilo_we, div0_o, div_en}, 32'h0);
        check("reset data", hi_o | lo_o | div_divident | div_divisor, 32'h0);
        @(posedge clk); #1;
        rst = 1'b1;

        do_op("divu 100/7",   1'b0, 32'd100, 32'd7, 20, 20, 1, 1'b0, 32'd14, 32'd2);
        do_op("divu 100/7 rep", 1'b0, 32'd100, 32'd7, 1, 1, 0, 1'b0, 32'd14, 32'd2);
        do_op("div -100/7 hit", 1'b1, 32'hFFFF_FF9C, 32'd7, 1, 1, 0, 1'b0,
              32'hFFFF_FFF2, 32'hFFFF_FFFE);
        do_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 20, 20, 1, 1'b0,
              32'hFFFF_FFFD, 32'hFFFF_FFFF);
        do_op("div min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 20, 20, 1, 1'b0,
              32'h8000_0000, 32'h0);
        do_op("div 5/0", 1'b1, 32'd5, 32'd0, 1, 1, 0, 1'b1, 32'h8000_0000, 32'h0);
        do_op("div 5/1", 1'b1, 32'd5, 32'd1, 20, 20, 1, 1'b0, 32'd5, 32'd0);

        // Flush mid-run; the next issue waits out the drain before launching
        flush_op("flush 50/3", 32'd50, 32'd3);
        do_op("divu 9/2 after drain", 1'b0, 32'd9, 32'd2, 32, 20, 1, 1'b0, 32'd4, 32'd1);
        do_op("divu 50/3", 1'b0, 32'd50, 32'd3, -1, 0, 0, 1'b0, 32'd16, 32'd2);

        // A drained result must land in the cache
        flush_op("flush 60/4", 32'd60, 32'd4);
        repeat (13) begin @(posedge clk); #1; end
        do_op("divu 60/4 drained hit", 1'b0, 32'd60, 32'd4, 1, 1, 0, 1'b0, 32'd15, 32'd0);

        // Reset while busy; the previously cached pair must relaunch
        issue_valid = 1'b1; issue_signed = 1'b0; op_a = 32'd77; op_b = 32'd5;
        repeat (4) begin @(posedge clk); #1; end
        rst = 1'b0; issue_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        check("midrst ctrl", {28'h0, stall_o, hilo_we, div0_o, div_en}, 32'h0);
        check("midrst data", hi_o | lo_o | div_divident | div_divisor, 32'h0);
        @(posedge clk); #1;
        do_op("divu 60/4 post-rst", 1'b0, 32'd60, 32'd4, 20, 20, 1, 1'b0, 32'd15, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
